// File: rtl/tpu_pkg.sv
// tpu_pkg: shared sequencer types and defaults for the
// systolic-array A/B operand loaders and top-level control.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ld_state_e;

  localparam int DEF_BITS_AB = 8;
  localparam int DEF_DIM     = 8;

  // a DIM x DIM skewed wavefront needs 3*DIM-2 shifts
  function automatic int run_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/mema_loader_up_counter.sv
// up_counter: clearable up counter that holds at its
// terminal value; ports clk, rst_n, clr, inc, q, tc.
module up_counter #(
  parameter int W  = 3,
  parameter int TC = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         tc
);

  localparam logic [W-1:0] TCV = W'(TC);

  assign tc = (q == TCV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !tc) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/mema_loader.sv
// mema_loader: A-operand skew buffer write sequencer.
// Ports: clk, rst_n, start, stall, in_valid/in_ready/in_row
// (row stream), WrEn/Arow/Ain (buffer row write), en
// (buffer shift), busy, done (run-complete pulse).
module mema_loader
  import tpu_pkg::*;
#(
  parameter int BITS_AB    = DEF_BITS_AB,
  parameter int DIM        = DEF_DIM,
  parameter int RUN_CYCLES = run_cycles(DIM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stall,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DIM*BITS_AB-1:0] in_row,
  output logic                          WrEn,
  output logic [$clog2(DIM)-1:0]        Arow,
  output logic signed [DIM*BITS_AB-1:0] Ain,
  output logic                          en,
  output logic                          busy,
  output logic                          done
);

  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(RUN_CYCLES + 1);

  ld_state_e state;
  ld_state_e state_nx;

  logic          hs;
  logic          en_i;
  logic          load_clr;
  logic          run_clr;
  logic          row_tc;
  logic          run_tc;
  logic [RW-1:0] row_q;
  logic [CW-1:0] run_q;
  logic          run_q_unused;

  assign in_ready = (state == LOAD);
  assign hs       = in_valid & in_ready;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign load_clr = (state == IDLE) & start;
  assign run_clr  = hs & row_tc;

  // The first RUN cycle still carries the final row write,
  // so shifting waits one cycle to keep WrEn and en apart.
  assign en_i = (state == RUN) & ~stall & ~WrEn;
  assign en   = en_i;

  assign run_q_unused = ^run_q;

  up_counter #(
    .W  (RW),
    .TC (DIM - 1)
  ) u_row_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_clr),
    .inc   (hs),
    .q     (row_q),
    .tc    (row_tc)
  );

  up_counter #(
    .W  (CW),
    .TC (RUN_CYCLES - 1)
  ) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_clr),
    .inc   (en_i),
    .q     (run_q),
    .tc    (run_tc)
  );

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE: if (start) state_nx = LOAD;
      state == LOAD: if (run_clr) state_nx = RUN;
      state == RUN:  if (en_i && run_tc) state_nx = DONE;
      state == DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      WrEn  <= 1'b0;
      Arow  <= '0;
      Ain   <= '0;
    end else begin
      state <= state_nx;
      WrEn  <= hs;
      if (hs) begin
        Arow <= row_q;
        Ain  <= in_row;
      end
    end
  end

endmodule

// File: tb/tb_mema_loader.sv
// tb_mema_loader: randomized self-checking bench for
// mema_loader at DIM=8 and DIM=2.
module tb_mema_loader;

  localparam int BITS = 8;
  localparam int DIM  = 8;
  localparam int RUN  = 3 * DIM - 2;
  localparam int W    = DIM * BITS;
  localparam int DIM2 = 2;
  localparam int RUN2 = 3 * DIM2 - 2;
  localparam int W2   = DIM2 * BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start = 1'b0;
  logic stall = 1'b0;
  logic in_valid = 1'b0;
  logic signed [W-1:0] in_row = '0;
  logic in_ready, WrEn, en, busy, done;
  logic [2:0] Arow;
  logic signed [W-1:0] Ain;

  logic s_start = 1'b0;
  logic s_stall = 1'b0;
  logic s_valid = 1'b0;
  logic signed [W2-1:0] s_row = '0;
  logic s_ready, s_wren, s_en, s_busy, s_done;
  logic [0:0] s_arow;
  logic signed [W2-1:0] s_ain;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int wr_row[$];
  logic [W-1:0] wr_dat[$];
  int wr_cyc[$];
  int en_cyc[$];
  int done_cyc[$];
  int both_hi = 0;

  int s_wr_row[$];
  logic [W2-1:0] s_wr_dat[$];
  int s_en_n = 0;
  int s_done_n = 0;

  mema_loader #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .WrEn(WrEn), .Arow(Arow), .Ain(Ain), .en(en),
    .busy(busy), .done(done)
  );

  mema_loader #(.BITS_AB(BITS), .DIM(DIM2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .stall(s_stall),
    .in_valid(s_valid), .in_ready(s_ready), .in_row(s_row),
    .WrEn(s_wren), .Arow(s_arow), .Ain(s_ain), .en(s_en),
    .busy(s_busy), .done(s_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (WrEn) begin
        wr_row.push_back(int'(Arow));
        wr_dat.push_back(Ain);
        wr_cyc.push_back(cyc);
      end
      if (en) en_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
      if (WrEn && en) both_hi++;
      if (s_wren) begin
        s_wr_row.push_back(int'(s_arow));
        s_wr_dat.push_back(s_ain);
      end
      if (s_en) s_en_n++;
      if (s_done) s_done_n++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_row.delete();
    wr_dat.delete();
    wr_cyc.delete();
    en_cyc.delete();
    done_cyc.delete();
    both_hi = 0;
  endtask

  task automatic make_rows(input bit pattern,
                           output logic signed [W-1:0] rows [DIM]);
    for (int r = 0; r < DIM; r++) begin
      rows[r] = {$urandom, $urandom};
      if (pattern)
        for (int i = 0; i < DIM; i++)
          rows[r][i*BITS +: BITS] = BITS'(r * 8 + i);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_rows(input logic signed [W-1:0] rows [DIM],
                           input bit gapped, input int nrows,
                           input bit start_mid);
    int r = 0;
    int guard = 0;
    bit tog = 1'b1;
    bit hs;
    while (r < nrows && guard < 200) begin
      in_valid = gapped ? tog : 1'b1;
      tog = ~tog;
      in_row = rows[r];
      start = start_mid && r == 3;
      hs = in_valid && in_ready;
      tick();
      if (hs) r++;
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (r < nrows) begin
      checks++;
      errors++;
      $display("FAIL send_rows: sent %0d want %0d", r, nrows);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%0b want 1", name, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_after: busy=%0b want 0", name, busy);
    end
  endtask

  task automatic check_writes(input logic signed [W-1:0] rows [DIM],
                              input string name);
    checks++;
    if (wr_row.size() != DIM) begin
      errors++;
      $display("FAIL %s_wr_count: got %0d want %0d",
               name, wr_row.size(), DIM);
    end else begin
      for (int i = 0; i < DIM; i++) begin
        checks++;
        if (wr_row[i] != i || wr_dat[i] !== rows[i]) begin
          errors++;
          $display("FAIL %s_row%0d: Arow=%0d Ain=%h want %0d %h",
                   name, i, wr_row[i], wr_dat[i], i, rows[i]);
        end
      end
    end
  endtask

  task automatic check_run(input string name, input int nstall);
    int first_en, last_en, last_wr;
    first_en = en_cyc.size() > 0 ? en_cyc[0] : -100;
    last_en  = en_cyc.size() > 0 ? en_cyc[en_cyc.size()-1] : -100;
    last_wr  = wr_cyc.size() > 0 ? wr_cyc[wr_cyc.size()-1] : -100;
    checks++;
    if (en_cyc.size() != RUN) begin
      errors++;
      $display("FAIL %s_en_count: got %0d want %0d",
               name, en_cyc.size(), RUN);
    end
    checks++;
    if (first_en != last_wr + 1) begin
      errors++;
      $display("FAIL %s_first_en: cycle %0d want %0d",
               name, first_en, last_wr + 1);
    end
    checks++;
    if (last_en - first_en + 1 != RUN + nstall) begin
      errors++;
      $display("FAIL %s_en_span: got %0d want %0d",
               name, last_en - first_en + 1, RUN + nstall);
    end
    checks++;
    if (done_cyc.size() != 1 ||
        done_cyc[0] != last_wr + RUN + nstall + 1) begin
      errors++;
      $display("FAIL %s_done: pulses=%0d cycle=%0d want 1 at %0d",
               name, done_cyc.size(),
               done_cyc.size() > 0 ? done_cyc[0] : -1,
               last_wr + RUN + nstall + 1);
    end
    checks++;
    if (both_hi != 0) begin
      errors++;
      $display("FAIL %s_wren_en_overlap: got %0d want 0",
               name, both_hi);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({in_ready, WrEn, Arow, Ain, en, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {in_ready, WrEn, Arow, Ain, en, busy, done});
    end
    checks++;
    if ({s_ready, s_wren, s_arow, s_ain, s_en, s_busy, s_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_dim2: got %h want 0",
               {s_ready, s_wren, s_arow, s_ain, s_en, s_busy, s_done});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic signed [W-1:0] rows [DIM];
    make_rows(1'b1, rows);
    clear_mon();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: ready=%0b busy=%0b want 0 0",
               in_ready, busy);
    end
    do_start();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start_latency: ready=%0b busy=%0b want 1 1",
               in_ready, busy);
    end
    send_rows(rows, 1'b0, DIM, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_after_last: got %0b want 0", in_ready);
    end
    wait_done("b2b");
    check_writes(rows, "b2b");
    checks++;
    if (wr_cyc.size() != DIM || wr_cyc[DIM-1] - wr_cyc[0] != DIM - 1) begin
      errors++;
      $display("FAIL b2b_consecutive: writes=%0d span=%0d want %0d",
               wr_cyc.size(),
               wr_cyc.size() > 0 ? wr_cyc[wr_cyc.size()-1] - wr_cyc[0] : -1,
               DIM - 1);
    end
    check_run("b2b", 0);
  endtask

  task automatic test_gapped();
    logic signed [W-1:0] rows [DIM];
    int bad = 0;
    make_rows(1'b0, rows);
    clear_mon();
    do_start();
    send_rows(rows, 1'b1, DIM, 1'b0);
    wait_done("gap");
    check_writes(rows, "gap");
    for (int i = 1; i < wr_cyc.size(); i++)
      if (wr_cyc[i] - wr_cyc[i-1] != 2) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gap_spacing: %0d bad gaps want 0", bad);
    end
    check_run("gap", 0);
  endtask

  task automatic test_stall();
    logic signed [W-1:0] rows [DIM];
    make_rows(1'b0, rows);
    clear_mon();
    do_start();
    send_rows(rows, 1'b0, DIM, 1'b0);
    repeat (4) tick();
    stall = 1'b1;
    repeat (5) tick();
    stall = 1'b0;
    wait_done("stall");
    check_writes(rows, "stall");
    check_run("stall", 5);
  endtask

  task automatic test_ignored();
    logic signed [W-1:0] rows [DIM];
    int rdy = 0;
    make_rows(1'b0, rows);
    clear_mon();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_row = {$urandom, $urandom};
      tick();
      if (in_ready) rdy++;
    end
    in_valid = 1'b0;
    stall = 1'b0;
    checks++;
    if (rdy != 0 || wr_row.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_idle: ready=%0d writes=%0d busy=%0b want 0 0 0",
               rdy, wr_row.size(), busy);
    end
    do_start();
    send_rows(rows, 1'b0, DIM, 1'b1);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      in_valid = 1'b1;
      in_row = {$urandom, $urandom};
      tick();
      if (in_ready) rdy++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (rdy != 0) begin
      errors++;
      $display("FAIL ign_run_ready: got %0d want 0", rdy);
    end
    wait_done("ign");
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ign_stay_idle: busy=%0b ready=%0b want 0 0",
               busy, in_ready);
    end
    check_writes(rows, "ign");
    check_run("ign", 0);
  endtask

  task automatic test_reset_midload();
    logic signed [W-1:0] rows [DIM];
    make_rows(1'b0, rows);
    clear_mon();
    do_start();
    send_rows(rows, 1'b0, 4, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, WrEn, Arow, Ain, en, busy, done} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h want 0",
               {in_ready, WrEn, Arow, Ain, en, busy, done});
    end
    tick();
    rst_n = 1'b1;
    tick();
    make_rows(1'b0, rows);
    clear_mon();
    do_start();
    send_rows(rows, 1'b0, DIM, 1'b0);
    wait_done("rst_mid");
    check_writes(rows, "rst_mid");
    check_run("rst_mid", 0);
  endtask

  task automatic test_dim2();
    logic signed [W2-1:0] rows [DIM2];
    int n = 0;
    bit ok;
    s_wr_row.delete();
    s_wr_dat.delete();
    s_en_n = 0;
    s_done_n = 0;
    for (int r = 0; r < DIM2; r++) rows[r] = W2'($urandom);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int r = 0; r < DIM2; r++) begin
      s_valid = 1'b1;
      s_row = rows[r];
      tick();
    end
    s_valid = 1'b0;
    while (!s_done && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    ok = s_wr_row.size() == DIM2;
    for (int i = 0; i < s_wr_row.size() && ok; i++)
      ok = s_wr_row[i] == i && s_wr_dat[i] === rows[i];
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dim2_writes: count=%0d want %0d (rows/data)",
               s_wr_row.size(), DIM2);
    end
    checks++;
    if (s_en_n != RUN2) begin
      errors++;
      $display("FAIL dim2_en_count: got %0d want %0d", s_en_n, RUN2);
    end
    checks++;
    if (s_done_n != 1 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL dim2_done: pulses=%0d busy=%0b want 1 0",
               s_done_n, s_busy);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_stall();
    test_ignored();
    test_reset_midload();
    test_dim2();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
